// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite memory writer path.
// Palette RGB values must match what the sprite ROM readers decode.
package sprite_pkg;

  // 2-bit palette index stored in each sprite memory word
  typedef logic [1:0] pal_idx_t;

  localparam logic [23:0] PAL_TRANSP_RGB = 24'hFFCCFF;
  localparam logic [23:0] PAL_BLACK_RGB  = 24'h000000;
  localparam logic [23:0] PAL_BLUE_RGB   = 24'h0000FF;

  localparam pal_idx_t IDX_TRANSP = 2'd0;
  localparam pal_idx_t IDX_BLACK  = 2'd1;
  localparam pal_idx_t IDX_OTHER  = 2'd2;
  localparam pal_idx_t IDX_BLUE   = 2'd3;

  // Words per sprite bank
  localparam int SPRITE_DEPTH = 6001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_palette_enc.sv
// Combinational RGB24 -> palette index encoder. Colours outside the
// palette map to IDX_OTHER and raise the unknown flag.
module sprite_palette_enc
  import sprite_pkg::*;
(
  input  logic [23:0] rgb,
  output pal_idx_t    idx,
  output logic        unknown
);

  // Exact-match lookup against the three palette colours
  always_comb begin
    idx     = IDX_OTHER;
    unknown = 1'b0;
    case (rgb)
      PAL_TRANSP_RGB: idx = IDX_TRANSP;
      PAL_BLACK_RGB:  idx = IDX_BLACK;
      PAL_BLUE_RGB:   idx = IDX_BLUE;
      default:        unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/sprite_loader.sv
// Sprite memory writer: encodes a 24-bit RGB pixel stream to palette
// indices and writes them sequentially into one of four sprite banks.
// Optional build macro SPRITE_LOADER_CKSUM_EN adds a running checksum of
// written indices (cksum) compared at the end against exp_cksum.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int DEPTH = SPRITE_DEPTH,
  parameter int AW    = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [1:0]    bank_sel,
  input  logic [AW-1:0] length,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [23:0]   pix_rgb,
  input  logic          pix_last,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [1:0]    wbank,
  output logic [1:0]    wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] unk_cnt
`ifdef SPRITE_LOADER_CKSUM_EN
  ,
  input  logic [15:0]   exp_cksum,
  output logic [15:0]   cksum
`endif
);

  state_e        state;
  logic [1:0]    bank_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] cnt;
  pal_idx_t      enc_idx;
  logic          enc_unk;
  logic          accept;
  logic          at_last;
  logic          at_end;
  logic          cksum_ok;
  logic          term_ok;
  logic          term_err;

  sprite_palette_enc u_enc (
    .rgb     (pix_rgb),
    .idx     (enc_idx),
    .unknown (enc_unk)
  );

  assign pix_ready = (state == S_LOAD);
  assign busy      = (state == S_LOAD);
  assign done      = (state == S_FINISH);
  assign accept    = pix_valid & pix_ready;
  assign at_last   = (cnt == len_q - AW'(1));
  // The pixel at address DEPTH-1 is the last one the bank can hold
  assign at_end    = (cnt == AW'(DEPTH - 1));

`ifdef SPRITE_LOADER_CKSUM_EN
  logic [15:0] exp_cksum_q;
  logic [15:0] cksum_nxt;
  // Include the terminating pixel so the comparison sees the final sum
  assign cksum_nxt = cksum + {14'd0, enc_idx};
  assign cksum_ok  = (cksum_nxt == exp_cksum_q);

  // Running sum of written indices, restarted on each accepted start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cksum       <= '0;
      exp_cksum_q <= '0;
    end else if (state == S_IDLE && start) begin
      cksum       <= '0;
      exp_cksum_q <= exp_cksum;
    end else if (accept) begin
      cksum <= cksum_nxt;
    end
  end
`else
  assign cksum_ok = 1'b1;
`endif

  // A matched length+last with a good checksum finishes; any other
  // terminating condition (length, last, bank end, checksum) is an error.
  assign term_ok  = at_last & pix_last & cksum_ok;
  assign term_err = at_last | pix_last | at_end;

  // Load FSM, write port register and status counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      bank_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wbank   <= '0;
      wdata   <= '0;
      err     <= 1'b0;
      unk_cnt <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bank_q  <= bank_sel;
            len_q   <= length;
            cnt     <= '0;
            unk_cnt <= '0;
            if (length == '0) begin
              err   <= 1'b1;
              state <= S_ERROR;
            end else begin
              err   <= 1'b0;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            we    <= 1'b1;
            waddr <= cnt;
            wbank <= bank_q;
            wdata <= enc_idx;
            cnt   <= cnt + AW'(1);
            if (enc_unk && unk_cnt != '1) begin
              unk_cnt <= unk_cnt + AW'(1);
            end
            if (term_ok) begin
              state <= S_FINISH;
            end else if (term_err) begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        S_ERROR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: expected writes are queued as pixels
// are driven and compared when the write strobe appears.
module tb_sprite_loader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  bank_sel = '0;
  logic [15:0] length = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [23:0] pix_rgb = '0;
  logic        pix_last = 1'b0;
  logic        we;
  logic [15:0] waddr;
  logic [1:0]  wbank;
  logic [1:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] unk_cnt;
`ifdef SPRITE_LOADER_CKSUM_EN
  logic [15:0] exp_cksum = '0;
  logic [15:0] cksum;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [19:0] exp_q[$];

  sprite_loader dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .bank_sel  (bank_sel),
    .length    (length),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_rgb   (pix_rgb),
    .pix_last  (pix_last),
    .we        (we),
    .waddr     (waddr),
    .wbank     (wbank),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .unk_cnt   (unk_cnt)
`ifdef SPRITE_LOADER_CKSUM_EN
    ,
    .exp_cksum (exp_cksum),
    .cksum     (cksum)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [23:0] rgb);
    case (rgb)
      24'hFFCCFF: return 2'd0;
      24'h000000: return 2'd1;
      24'h0000FF: return 2'd3;
      default:    return 2'd2;
    endcase
  endfunction

  // Write monitor: every strobe must match the oldest queued write
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (done) n_done++;
      if (we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 64'(waddr), 64'hFFFFF);
        end else begin
          chk("write", 64'({waddr, wbank, wdata}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] b, input logic [15:0] l, input logic [15:0] ec);
    start    = 1'b1;
    bank_sel = b;
    length   = l;
`ifdef SPRITE_LOADER_CKSUM_EN
    exp_cksum = ec;
`else
    if (ec != 16'd0) $display("note: checksum %0d unused in this build", ec);
`endif
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [23:0] rgb, input logic last,
                      input logic [15:0] addr, input logic [1:0] bank);
    chk("pix_ready", 64'(pix_ready), 64'd1);
    pix_valid = 1'b1;
    pix_rgb   = rgb;
    pix_last  = last;
    exp_q.push_back({addr, bank, enc(rgb)});
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return 64'({we, waddr, wbank, wdata, pix_ready, busy, done, err, unk_cnt});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #22;
    chk("reset_outputs", outs(), 64'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Nominal load: all four encodings, back-to-back pixels
    d0 = n_done;
    do_start(2'd2, 16'd4, 16'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    send(24'hFFCCFF, 1'b0, 16'd0, 2'd2);
    send(24'h000000, 1'b0, 16'd1, 2'd2);
    send(24'h0000FF, 1'b0, 16'd2, 2'd2);
    send(24'h123456, 1'b1, 16'd3, 2'd2);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_ready_drop", 64'(pix_ready), 64'd0);
    chk("t1_unk_cnt", 64'(unk_cnt), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    tick();
    chk("t1_done_count", 64'(n_done - d0), 64'd1);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Short stream: last arrives early
    d0 = n_done;
    do_start(2'd1, 16'd3, 16'd0);
    chk("t2_unk_cleared", 64'(unk_cnt), 64'd0);
    send(24'h0000FF, 1'b0, 16'd0, 2'd1);
    send(24'hABCDEF, 1'b1, 16'd1, 2'd1);
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_ready", 64'(pix_ready), 64'd0);
    tick();
    chk("t2_err_sticky", 64'(err), 64'd1);
    chk("t2_ready_idle", 64'(pix_ready), 64'd0);
    tick();
    chk("t2_no_done", 64'(n_done - d0), 64'd0);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // Long stream: length reached without last
    do_start(2'd3, 16'd3, 16'd0);
    send(24'h000000, 1'b0, 16'd0, 2'd3);
    send(24'hFFCCFF, 1'b0, 16'd1, 2'd3);
    send(24'h000000, 1'b0, 16'd2, 2'd3);
    chk("t3_err", 64'(err), 64'd1);
    tick();
    tick();
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero length errors immediately; next start clears err
    do_start(2'd0, 16'd0, 16'd0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    tick();
    tick();
    do_start(2'd0, 16'd1, 16'd0);
    chk("t4_err_cleared", 64'(err), 64'd0);
    send(24'h0000FF, 1'b1, 16'd0, 2'd0);
    chk("t4_done", 64'(done), 64'd1);
    tick();

    // Gapped valid with an ignored start mid-load
    do_start(2'd1, 16'd2, 16'd0);
    send(24'h000000, 1'b0, 16'd0, 2'd1);
    start    = 1'b1;
    bank_sel = 2'd3;
    length   = 16'd9;
    tick();
    start = 1'b0;
    chk("t5_busy", 64'(busy), 64'd1);
    tick();
    send(24'hFFCCFF, 1'b1, 16'd1, 2'd1);
    chk("t5_done", 64'(done), 64'd1);
    tick();
    tick();
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a load
    do_start(2'd2, 16'd5, 16'd0);
    send(24'h000000, 1'b0, 16'd0, 2'd2);
    send(24'h0000FF, 1'b0, 16'd1, 2'd2);
    #1;
    chk("t6_we_before_reset", 64'({we, waddr, wbank, wdata}), 64'(exp_q.pop_front() | 20'h0) | 64'h100000);
    Reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", outs(), 64'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    do_start(2'd2, 16'd1, 16'd0);
    send(24'h123456, 1'b1, 16'd0, 2'd2);
    chk("t6_restart_done", 64'(done), 64'd1);
    tick();
    tick();
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

    // Bank end: length larger than DEPTH stops after address DEPTH-1
    do_start(2'd0, 16'd7000, 16'd0);
    for (int i = 0; i < 6001; i++) begin
      pix_valid = 1'b1;
      pix_rgb   = 24'h0000FF;
      pix_last  = 1'b0;
      exp_q.push_back({16'(i), 2'd0, 2'd3});
      tick();
    end
    pix_valid = 1'b0;
    chk("t7_err_depth", 64'(err), 64'd1);
    chk("t7_ready", 64'(pix_ready), 64'd0);
    tick();
    tick();
    chk("t7_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef SPRITE_LOADER_CKSUM_EN
    // Checksum match finishes, mismatch errors
    do_start(2'd1, 16'd3, 16'd3);
    send(24'h000000, 1'b0, 16'd0, 2'd1);
    send(24'h000000, 1'b0, 16'd1, 2'd1);
    send(24'h000000, 1'b1, 16'd2, 2'd1);
    chk("t8_done", 64'(done), 64'd1);
    chk("t8_cksum", 64'(cksum), 64'd3);
    tick();
    do_start(2'd1, 16'd3, 16'd4);
    send(24'h000000, 1'b0, 16'd0, 2'd1);
    send(24'h000000, 1'b0, 16'd1, 2'd1);
    send(24'h000000, 1'b1, 16'd2, 2'd1);
    chk("t8_bad_done", 64'(done), 64'd0);
    chk("t8_bad_err", 64'(err), 64'd1);
    tick();
    tick();
    chk("t8_q_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
